pe_group: RTL and testbench

- Array of `para_deg` independent unsigned multiply-accumulate processing elements (PEs), used as the parallel compute core of the dot-product datapath.
- Each lane multiplies one element of `data0` by the matching element of `data1`.
- The product is added either to a caller-supplied partial sum (`old_output`) or to the lane's own running accumulator.
- The result is registered, one accumulator per lane.

---
 rtl/pe_group_pkg.sv | 16 +
 rtl/pe_mac_lane.sv | 44 ++++
 rtl/pe_group.sv | 31 +++
 tb/tb_pe_group.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pe_group_pkg.sv
// Shared constants and lane-slicing helpers for the pe_group MAC array.
package pe_group_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PARA_DEG   = 3;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  function automatic int data_off(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int acc_off(input int lane, input int width);
    return lane * 2 * width;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// Single unsigned multiply-accumulate lane with one registered accumulator.
module pe_mac_lane
  import pe_group_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_old_output,
  input  logic [data_width-1:0]   a,
  input  logic [data_width-1:0]   b,
  input  logic [2*data_width-1:0] old_sum,
  output logic [2*data_width-1:0] sum
);

  logic [2*data_width-1:0] prod_s;
  logic [2*data_width-1:0] base_s;
  logic [2*data_width-1:0] acc_d;
  logic [2*data_width-1:0] acc_q;

  // Next accumulator value: seed or own sum plus the full-width product, wrapping.
  always_comb begin
    prod_s = {{data_width{1'b0}}, a} * {{data_width{1'b0}}, b};
    base_s = acc_q;
    if (load_old_output) begin
      base_s = old_sum;
    end else begin
      base_s = acc_q;
    end
    acc_d = base_s + prod_s;
  end

  // Accumulator register, cleared immediately while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= {(2*data_width){1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum = acc_q;

endmodule

// File: rtl/pe_group.sv
// Array of para_deg independent MAC lanes; this level only slices and joins buses.
module pe_group
  import pe_group_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int para_deg   = PARA_DEG
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_old_output,
  input  logic [para_deg*data_width-1:0]   data0,
  input  logic [para_deg*data_width-1:0]   data1,
  output logic [para_deg*2*data_width-1:0] result,
  input  logic [para_deg*2*data_width-1:0] old_output
);

  for (genvar i = 0; i < para_deg; i++) begin : g_lane
    pe_mac_lane #(
      .data_width(data_width)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .load_old_output(load_old_output),
      .a              (data0[data_off(i, data_width) +: data_width]),
      .b              (data1[data_off(i, data_width) +: data_width]),
      .old_sum        (old_output[acc_off(i, data_width) +: 2*data_width]),
      .sum            (result[acc_off(i, data_width) +: 2*data_width])
    );
  end

endmodule

// File: tb/tb_pe_group.sv
// Directed and model-checked bench for pe_group with default 8-bit, 3-lane sizing.
module tb_pe_group;

  localparam int DW = 8;
  localparam int PD = 3;
  localparam int AW = 2 * DW;

  logic              clk;
  logic              reset;
  logic              load_old_output;
  logic [PD*DW-1:0]  data0;
  logic [PD*DW-1:0]  data1;
  logic [PD*AW-1:0]  result;
  logic [PD*AW-1:0]  old_output;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] acc_m [PD];

  pe_group #(.data_width(DW), .para_deg(PD)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_old_output(load_old_output),
    .data0          (data0),
    .data1          (data1),
    .result         (result),
    .old_output     (old_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] old);
    data0[i*DW +: DW]      = a;
    data1[i*DW +: DW]      = b;
    old_output[i*AW +: AW] = old;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic [AW-1:0] e0,
                             input logic [AW-1:0] e1, input logic [AW-1:0] e2);
    check({tag, "_l0"}, result[0*AW +: AW], e0);
    check({tag, "_l1"}, result[1*AW +: AW], e1);
    check({tag, "_l2"}, result[2*AW +: AW], e2);
  endtask

  initial begin
    reset           = 1'b0;
    load_old_output = 1'b1;
    data0           = {PD*DW{1'b0}};
    data1           = {PD*DW{1'b0}};
    old_output      = {PD*AW{1'b0}};

    // Reset held low: random inputs must not disturb the cleared accumulators.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < PD; i++)
        set_lane(i, DW'($urandom), DW'($urandom), AW'($urandom));
      load_old_output = 1'($urandom);
      step();
      check_lanes("reset_hold", 16'd0, 16'd0, 16'd0);
    end

    reset = 1'b1;
    load_old_output = 1'b1;
    set_lane(0, 8'd3,   8'd4,   16'd10);
    set_lane(1, 8'd255, 8'd255, 16'd0);
    set_lane(2, 8'd0,   8'd77,  16'd500);
    step();
    check_lanes("load", 16'd22, 16'd65025, 16'd500);

    load_old_output = 1'b0;
    set_lane(0, 8'd2, 8'd5, 16'd999);
    set_lane(1, 8'd0, 8'd9, 16'd999);
    set_lane(2, 8'd0, 8'd9, 16'd999);
    step();
    check_lanes("acc1", 16'd32, 16'd65025, 16'd500);
    step();
    check_lanes("acc2", 16'd42, 16'd65025, 16'd500);
    step();
    check_lanes("acc3", 16'd52, 16'd65025, 16'd500);

    load_old_output = 1'b1;
    set_lane(0, 8'd0, 8'd0, 16'd0);
    set_lane(1, 8'd1, 8'd1, 16'd65535);
    set_lane(2, 8'd2, 8'd3, 16'd7);
    step();
    check_lanes("wrap", 16'd0, 16'd0, 16'd13);

    load_old_output = 1'b0;
    set_lane(0, 8'd0,   8'd0,   16'd0);
    set_lane(1, 8'd255, 8'd255, 16'd0);
    set_lane(2, 8'd0,   8'd0,   16'd0);
    step();
    check_lanes("after_wrap", 16'd0, 16'd65025, 16'd13);

    // Random lanes against an independent per-lane model, modulo 2^16.
    acc_m[0] = 16'd0;
    acc_m[1] = 16'd65025;
    acc_m[2] = 16'd13;
    for (int c = 0; c < 100; c++) begin
      load_old_output = 1'($urandom);
      for (int i = 0; i < PD; i++) begin
        logic [DW-1:0] ra, rb;
        logic [AW-1:0] ro;
        ra = DW'($urandom);
        rb = DW'($urandom);
        ro = AW'($urandom);
        set_lane(i, ra, rb, ro);
        acc_m[i] = (load_old_output ? ro : acc_m[i]) + AW'(ra) * AW'(rb);
      end
      step();
      for (int i = 0; i < PD; i++)
        check($sformatf("rand_c%0d_l%0d", c, i), result[i*AW +: AW], acc_m[i]);
    end

    load_old_output = 1'b1;
    for (int i = 0; i < PD; i++) set_lane(i, 8'd1, 8'd1, 16'd100);
    step();
    check_lanes("pre_reset", 16'd101, 16'd101, 16'd101);

    // Short reset pulse between edges must clear immediately.
    load_old_output = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check_lanes("async_clr", 16'd0, 16'd0, 16'd0);
    #2;
    reset = 1'b1;
    step();
    check_lanes("post_reset", 16'd1, 16'd1, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
